// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants for the keyboard byte buffer.
//   - Port addresses for the data (60h) and status/command (64h) ports.
//   - Command codes accepted on the status/command port.
//   - Bit positions inside the status byte.
package kbd_pkg;

    localparam logic [15:0] KBD_PORT_DATA = 16'h0060;
    localparam logic [15:0] KBD_PORT_STAT = 16'h0064;

    localparam logic [7:0] KBD_CMD_DIS   = 8'hAD;
    localparam logic [7:0] KBD_CMD_EN    = 8'hAE;
    localparam logic [7:0] KBD_CMD_FLUSH = 8'hC0;

    // Status byte layout: {5'b0, enable, ovf, not_empty}
    localparam int KBD_STAT_NE  = 0;
    localparam int KBD_STAT_OVF = 1;
    localparam int KBD_STAT_EN  = 2;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: small synchronous byte FIFO built from a register array.
//   clock  in   system clock, posedge
//   reset  in   asynchronous active-high reset
//   push   in   write din at the tail (ignored when full unless popping)
//   din    in   byte to write
//   pop    in   drop the head byte (ignored when empty)
//   flush  in   empty the FIFO; push/pop in the same cycle are discarded
//   head   out  byte at the head of the queue (stale when empty)
//   count  out  number of bytes held, DEPTH_LOG2+1 bits
module kbd_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    input  logic                  flush,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]              mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [DEPTH_LOG2-1:0]   rd_ptr_r;
    logic [DEPTH_LOG2:0]     count_r;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    // Qualify push/pop against occupancy; a full FIFO accepts a push only alongside a pop
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            pop_ok_s  = pop & (count_r != CNT_ZERO);
            push_ok_s = push & ((count_r != CNT_FULL) | pop_ok_s);
        end
    end

    // Storage, pointers and occupancy counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/kbd_buffer.sv
// kbd_buffer: keyboard byte buffer between the ps2 receiver and the CPU port bus.
//   clock    in   system clock (25 MHz), posedge
//   reset    in   asynchronous active-high reset
//   kb_done  in   one-cycle strobe, kb_data holds a new scan byte
//   kb_data  in   received scan byte
//   port_a   in   CPU port address
//   port_r   in   CPU port read strobe
//   port_w   in   CPU port write strobe
//   port_o   in   CPU port write data
//   port_i   out  read data, combinational from port_a
//   port_hit out  port_a addresses the data or status port
//   irq      out  registered one-cycle pulse each time a byte becomes head of queue
module kbd_buffer
    import kbd_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] PORT_DATA  = KBD_PORT_DATA,
    parameter logic [15:0] PORT_STAT  = KBD_PORT_STAT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         kb_done,
    input  logic [7:0]   kb_data,
    input  logic [15:0]  port_a,
    input  logic         port_r,
    input  logic         port_w,
    input  logic [7:0]   port_o,
    output logic [7:0]   port_i,
    output logic         port_hit,
    output logic         irq
);

    localparam logic [DEPTH_LOG2:0] CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            head_s;
    logic [DEPTH_LOG2:0]   count_s;
    logic [DEPTH_LOG2:0]   count_next_s;
    logic                  data_sel_s;
    logic                  stat_sel_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  kb_acc_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  stat_rd_s;
    logic                  ovf_set_s;
    logic                  enable_next_s;
    logic                  ovf_next_s;
    logic                  irq_next_s;
    logic [7:0]            stat_s;

    logic [7:0]            last_r;
    logic                  ovf_r;
    logic                  enable_r;
    logic                  irq_r;

    kbd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .din   (kb_data),
        .pop   (pop_s),
        .flush (flush_s),
        .head  (head_s),
        .count (count_s)
    );

    assign data_sel_s = (port_a == PORT_DATA);
    assign stat_sel_s = (port_a == PORT_STAT);
    assign port_hit   = data_sel_s | stat_sel_s;
    assign empty_s    = (count_s == CNT_ZERO);
    assign full_s     = (count_s == CNT_FULL);

    // Command decode on the status port
    always_comb begin
        enable_next_s = enable_r;
        flush_s       = 1'b0;
        if (port_w && stat_sel_s) begin
            case (port_o)
                KBD_CMD_DIS:   enable_next_s = 1'b0;
                KBD_CMD_EN:    enable_next_s = 1'b1;
                KBD_CMD_FLUSH: flush_s       = 1'b1;
                default:       enable_next_s = enable_r;
            endcase
        end else begin
            enable_next_s = enable_r;
        end
    end

    // Push/pop qualification, overflow detection and next occupancy
    always_comb begin
        kb_acc_s  = kb_done & enable_r;
        pop_s     = port_r & data_sel_s & ~empty_s;
        stat_rd_s = port_r & stat_sel_s;
        // A full FIFO still takes a byte when the CPU pops in the same cycle
        push_s    = kb_acc_s & ~flush_s & (~full_s | pop_s);
        ovf_set_s = kb_acc_s & ~flush_s & full_s & ~pop_s;
        if (flush_s) begin
            count_next_s = CNT_ZERO;
        end else if (push_s && !pop_s) begin
            count_next_s = count_s + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_s - CNT_ONE;
        end else begin
            count_next_s = count_s;
        end
    end

    // Overflow flag and irq next-state; a fresh overflow outranks the status-read clear
    always_comb begin
        if (flush_s) begin
            ovf_next_s = 1'b0;
        end else if (ovf_set_s) begin
            ovf_next_s = 1'b1;
        end else if (stat_rd_s) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
        // A new head appears when a pop exposes the next byte or a byte lands in an empty queue
        irq_next_s = (count_next_s != CNT_ZERO) & (pop_s | (push_s & empty_s));
    end

    // Status byte and combinational read mux
    always_comb begin
        stat_s               = 8'h00;
        stat_s[KBD_STAT_EN]  = enable_r;
        stat_s[KBD_STAT_OVF] = ovf_r;
        stat_s[KBD_STAT_NE]  = ~empty_s;
        if (data_sel_s) begin
            port_i = empty_s ? last_r : head_s;
        end else if (stat_sel_s) begin
            port_i = stat_s;
        end else begin
            port_i = 8'hFF;
        end
    end

    // Control registers: last popped byte, overflow, enable and irq pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_r   <= 8'h00;
            ovf_r    <= 1'b0;
            enable_r <= 1'b1;
            irq_r    <= 1'b0;
        end else begin
            if (pop_s) begin
                last_r <= head_s;
            end
            ovf_r    <= ovf_next_s;
            enable_r <= enable_next_s;
            irq_r    <= irq_next_s;
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_kbd_buffer.sv
module tb_kbd_buffer;

    localparam logic [15:0] PD = 16'h0060;
    localparam logic [15:0] PS = 16'h0064;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        kb_done = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic [15:0] port_a  = 16'h0000;
    logic        port_r  = 1'b0;
    logic        port_w  = 1'b0;
    logic [7:0]  port_o  = 8'h00;
    logic [7:0]  port_i;
    logic        port_hit;
    logic        irq;

    kbd_buffer dut (
        .clock    (clock),
        .reset    (reset),
        .kb_done  (kb_done),
        .kb_data  (kb_data),
        .port_a   (port_a),
        .port_r   (port_r),
        .port_w   (port_w),
        .port_o   (port_o),
        .port_i   (port_i),
        .port_hit (port_hit),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: byte queue plus flags
    logic [7:0] q[$];
    logic [7:0] m_last;
    bit         m_ovf;
    bit         m_en;
    bit         m_irq;

    logic [7:0] pi_v;
    logic       iq_v;

    typedef struct {
        bit          kd;
        logic [7:0]  d;
        logic [15:0] a;
        bit          r;
        bit          w;
        logic [7:0]  o;
        logic [7:0]  epi;
        bit          eirq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit kd, logic [7:0] d, logic [15:0] a, bit r, bit w,
                                logic [7:0] o, logic [7:0] epi, bit eirq);
        vec_t v;
        v.kd = kd; v.d = d; v.a = a; v.r = r; v.w = w; v.o = o; v.epi = epi; v.eirq = eirq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        q.delete();
        m_last = 8'h00;
        m_ovf  = 1'b0;
        m_en   = 1'b1;
        m_irq  = 1'b0;
    endfunction

    function automatic logic [7:0] m_port(logic [15:0] a);
        if (a == PD) return (q.size() > 0) ? q[0] : m_last;
        if (a == PS) return {5'b00000, m_en, m_ovf, q.size() > 0};
        return 8'hFF;
    endfunction

    function automatic void m_step(bit kd, logic [7:0] d, logic [15:0] a, bit r, bit w, logic [7:0] o);
        int old    = q.size();
        bit popped = 1'b0;
        bit ovf_new = 1'b0;
        if (w && a == PS && o == 8'hC0) begin
            q.delete();
            m_ovf = 1'b0;
            m_irq = 1'b0;
        end else begin
            if (r && a == PD && old > 0) begin
                m_last = q.pop_front();
                popped = 1'b1;
            end
            if (kd && m_en) begin
                if (q.size() < 16) q.push_back(d);
                else ovf_new = 1'b1;
            end
            m_irq = (q.size() > 0) && (popped || old == 0);
            if (ovf_new) m_ovf = 1'b1;
            else if (r && a == PS) m_ovf = 1'b0;
        end
        if (w && a == PS) begin
            if (o == 8'hAD) m_en = 1'b0;
            else if (o == 8'hAE) m_en = 1'b1;
        end
    endfunction

    // One bus cycle: drive at negedge, check read mux, clock, check irq, drop strobes
    task automatic step(input bit kd, input logic [7:0] d, input logic [15:0] a, input bit r,
                        input bit w, input logic [7:0] o, output logic [7:0] pi, output logic iq);
        @(negedge clock);
        kb_done = kd; kb_data = d; port_a = a; port_r = r; port_w = w; port_o = o;
        #1;
        chk("port_i", port_i, m_port(a));
        chk("port_hit", {7'b0, port_hit}, {7'b0, (a == PD) || (a == PS)});
        pi = port_i;
        @(posedge clock);
        m_step(kd, d, a, r, w, o);
        #1;
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        iq = irq;
        kb_done = 1'b0; port_r = 1'b0; port_w = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b0;
        port_a = PS;
        #1;
        chk("rst_stat", port_i, 8'h04);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        port_a = PD;
        #1;
        chk("rst_data", port_i, 8'h00);

        // Directed table: single byte, three-byte ordering, enable/disable/flush
        tbl.push_back(mk(1, 8'h1C, 16'h0000, 0, 0, 8'h00, 8'hFF, 1));
        tbl.push_back(mk(0, 8'h00, PS,       0, 0, 8'h00, 8'h05, 0));
        tbl.push_back(mk(0, 8'h00, PD,       1, 0, 8'h00, 8'h1C, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 0, 8'h00, 8'h04, 0));
        tbl.push_back(mk(0, 8'h00, PD,       0, 0, 8'h00, 8'h1C, 0));
        tbl.push_back(mk(1, 8'h1C, PS,       0, 0, 8'h00, 8'h04, 1));
        tbl.push_back(mk(1, 8'hF0, PS,       0, 0, 8'h00, 8'h05, 0));
        tbl.push_back(mk(1, 8'h1C, PS,       0, 0, 8'h00, 8'h05, 0));
        tbl.push_back(mk(0, 8'h00, PD,       1, 0, 8'h00, 8'h1C, 1));
        tbl.push_back(mk(0, 8'h00, PD,       1, 0, 8'h00, 8'hF0, 1));
        tbl.push_back(mk(0, 8'h00, PD,       1, 0, 8'h00, 8'h1C, 0));
        tbl.push_back(mk(0, 8'h00, PD,       1, 0, 8'h00, 8'h1C, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 1, 8'hAD, 8'h04, 0));
        tbl.push_back(mk(1, 8'h2A, PS,       0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 1, 8'hAE, 8'h00, 0));
        tbl.push_back(mk(1, 8'h2A, PS,       0, 0, 8'h00, 8'h04, 1));
        tbl.push_back(mk(1, 8'h3B, PS,       0, 0, 8'h00, 8'h05, 0));
        tbl.push_back(mk(1, 8'h4C, PS,       0, 0, 8'h00, 8'h05, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 1, 8'hC0, 8'h05, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 0, 8'h00, 8'h04, 0));
        tbl.push_back(mk(0, 8'h00, PD,       0, 0, 8'h00, 8'h1C, 0));
        tbl.push_back(mk(0, 8'h00, PD,       0, 1, 8'h55, 8'h1C, 0));
        tbl.push_back(mk(0, 8'h00, PS,       0, 1, 8'h12, 8'h04, 0));
        foreach (tbl[i]) begin
            step(tbl[i].kd, tbl[i].d, tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].o, pi_v, iq_v);
            chk($sformatf("tbl%0d_pi", i), pi_v, tbl[i].epi);
            chk($sformatf("tbl%0d_irq", i), {7'b0, iq_v}, {7'b0, tbl[i].eirq});
        end

        // Overflow: 17 pushes into an empty 16-deep queue
        for (int i = 1; i <= 17; i++) step(1, 8'(i), 16'h0000, 0, 0, 8'h00, pi_v, iq_v);
        step(0, 8'h00, PS, 1, 0, 8'h00, pi_v, iq_v);
        chk("ovf_stat", pi_v, 8'h07);
        step(0, 8'h00, PS, 0, 0, 8'h00, pi_v, iq_v);
        chk("ovf_clr", pi_v, 8'h05);
        for (int i = 1; i <= 16; i++) begin
            step(0, 8'h00, PD, 1, 0, 8'h00, pi_v, iq_v);
            chk("ovf_drain", pi_v, 8'(i));
        end
        step(0, 8'h00, PS, 0, 0, 8'h00, pi_v, iq_v);
        chk("ovf_empty", pi_v, 8'h04);

        // Push and pop together at count 1 and at full
        step(1, 8'hAA, 16'h0000, 0, 0, 8'h00, pi_v, iq_v);
        step(1, 8'hBB, PD, 1, 0, 8'h00, pi_v, iq_v);
        chk("pp1_pi", pi_v, 8'hAA);
        chk("pp1_irq", {7'b0, iq_v}, 8'h01);
        step(0, 8'h00, PD, 0, 0, 8'h00, pi_v, iq_v);
        chk("pp1_head", pi_v, 8'hBB);
        step(0, 8'h00, PS, 0, 0, 8'h00, pi_v, iq_v);
        chk("pp1_stat", pi_v, 8'h05);
        step(0, 8'h00, PD, 1, 0, 8'h00, pi_v, iq_v);
        for (int i = 0; i < 16; i++) step(1, 8'h20 + 8'(i), 16'h0000, 0, 0, 8'h00, pi_v, iq_v);
        step(1, 8'h55, PD, 1, 0, 8'h00, pi_v, iq_v);
        chk("ppf_pi", pi_v, 8'h20);
        chk("ppf_irq", {7'b0, iq_v}, 8'h01);
        step(0, 8'h00, PS, 0, 0, 8'h00, pi_v, iq_v);
        chk("ppf_stat", pi_v, 8'h05);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, PD, 1, 0, 8'h00, pi_v, iq_v);
            chk("ppf_drain", pi_v, (i < 15) ? 8'h21 + 8'(i) : 8'h55);
        end

        // Asynchronous reset with bytes queued and irq high
        for (int i = 0; i < 6; i++) step(1, 8'h61 + 8'(i), 16'h0000, 0, 0, 8'h00, pi_v, iq_v);
        step(0, 8'h00, PD, 1, 0, 8'h00, pi_v, iq_v);
        chk("pre_rst_irq", {7'b0, iq_v}, 8'h01);
        reset  = 1'b1;
        port_a = PS;
        #1;
        chk("arst_irq", {7'b0, irq}, 8'h00);
        chk("arst_stat", port_i, 8'h04);
        port_a = PD;
        #1;
        chk("arst_data", port_i, 8'h00);
        m_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            logic [7:0]  o;
            bit          r;
            bit          w;
            int          sel;
            sel = $urandom_range(0, 3);
            a = (sel < 2) ? PD : (sel == 2) ? PS : 16'($urandom);
            sel = $urandom_range(0, 9);
            r = (sel < 3);
            w = (sel == 3);
            sel = $urandom_range(0, 19);
            o = (sel < 3) ? 8'hAD : (sel < 8) ? 8'hAE : (sel == 8) ? 8'hC0 : 8'($urandom);
            step($urandom_range(0, 1) == 1, 8'($urandom), a, r, w, o, pi_v, iq_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
